// File: rtl/pcs_sync_param.sv
// 1000BASE-X PCS receive synchronization FSM with configurable thresholds.
// Ports: Clk, mr_main_reset_n, power_on, signal_detect, PUDI -> code_sync_status, rx_even, SUDI, sync_loss_count.
module pcs_sync_param #(
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CGS_MAX = 4,
  parameter int LOSS_STEPS   = 4,
  parameter int CNT_W        = 8
) (
  input  logic             Clk,
  input  logic             mr_main_reset_n,
  input  logic             power_on,
  input  logic             signal_detect,
  input  logic [9:0]       PUDI,
  output logic             code_sync_status,
  output logic             rx_even,
  output logic [10:0]      SUDI,
  output logic [CNT_W-1:0] sync_loss_count
);

  localparam int CC_W = $clog2(ACQ_COMMAS + 1);
  localparam int GC_W = $clog2(GOOD_CGS_MAX + 1);
  localparam int BL_W = $clog2(LOSS_STEPS + 1);

  localparam logic [CC_W-1:0] ACQ_C  = CC_W'(ACQ_COMMAS);
  localparam logic [GC_W-1:0] GC_MAX = GC_W'(GOOD_CGS_MAX);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(LOSS_STEPS);

  typedef enum logic [2:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    ACQUIRE_SYNC,
    SYNC_ACQUIRED,
    SYNC_RECOVER
  } state_t;

  state_t          state, state_n;
  logic [CC_W-1:0] comma_cnt, cc_n;
  logic [GC_W-1:0] good_cnt, gc_n;
  logic [BL_W-1:0] bad_lvl, bl_n;
  logic            rxe_n, status_n;

  logic comma, invalid, kcode, is_d, cggood;

  always_comb begin
    comma = (PUDI[9:3] == 7'b0011111) ||
            (PUDI[9:3] == 7'b1100000);
    invalid = ($countones(PUDI) < 4) ||
              ($countones(PUDI) > 6) ||
              ($countones(PUDI[9:4]) < 2) ||
              ($countones(PUDI[9:4]) > 4) ||
              ($countones(PUDI[3:0]) < 1) ||
              ($countones(PUDI[3:0]) > 3);
    // K28.x, then K23.7/K27.7/K29.7/K30.7 in both disparities
    kcode = (PUDI[9:4] == 6'b001111) ||
            (PUDI[9:4] == 6'b110000) ||
            (PUDI == 10'b1110101000) ||
            (PUDI == 10'b0001010111) ||
            (PUDI == 10'b1101101000) ||
            (PUDI == 10'b0010010111) ||
            (PUDI == 10'b1011101000) ||
            (PUDI == 10'b0100010111) ||
            (PUDI == 10'b0111101000) ||
            (PUDI == 10'b1000010111);
    is_d   = ~invalid & ~kcode;
    // a comma landing on an odd position is a bad code-group
    cggood = ~(invalid | (comma & ~rx_even));
  end

  always_comb begin
    state_n = state;
    rxe_n   = ~rx_even;
    cc_n    = comma_cnt;
    gc_n    = good_cnt;
    bl_n    = bad_lvl;
    if (!signal_detect) begin
      state_n = LOSS_OF_SYNC;
      cc_n    = '0;
      gc_n    = '0;
      bl_n    = '0;
    end else begin
      case (state)
        LOSS_OF_SYNC: begin
          cc_n = '0;
          gc_n = '0;
          bl_n = '0;
          if (comma) begin
            rxe_n   = 1'b0;
            cc_n    = CC_W'(1);
            state_n = COMMA_DETECT;
          end
        end
        COMMA_DETECT: begin
          rxe_n = 1'b1;
          if (is_d) begin
            if (comma_cnt >= ACQ_C) begin
              state_n = SYNC_ACQUIRED;
              bl_n    = '0;
              gc_n    = '0;
            end else begin
              state_n = ACQUIRE_SYNC;
            end
          end else begin
            state_n = LOSS_OF_SYNC;
            cc_n    = '0;
          end
        end
        ACQUIRE_SYNC: begin
          if (comma && rx_even) begin
            cc_n    = comma_cnt + 1'b1;
            state_n = COMMA_DETECT;
          end else if (!cggood) begin
            cc_n    = '0;
            state_n = LOSS_OF_SYNC;
          end
        end
        SYNC_ACQUIRED: begin
          if (!cggood) begin
            if (LOSS_STEPS == 1) begin
              cc_n    = '0;
              state_n = LOSS_OF_SYNC;
            end else begin
              bl_n    = BL_W'(1);
              gc_n    = '0;
              state_n = SYNC_RECOVER;
            end
          end
        end
        SYNC_RECOVER: begin
          if (cggood) begin
            if (good_cnt + 1'b1 >= GC_MAX) begin
              gc_n = '0;
              bl_n = bad_lvl - 1'b1;
              if (bad_lvl == BL_W'(1))
                state_n = SYNC_ACQUIRED;
            end else begin
              gc_n = good_cnt + 1'b1;
            end
          end else begin
            gc_n = '0;
            if (bad_lvl + 1'b1 >= BL_MAX) begin
              bl_n    = '0;
              cc_n    = '0;
              state_n = LOSS_OF_SYNC;
            end else begin
              bl_n = bad_lvl + 1'b1;
            end
          end
        end
        default: begin
          state_n = LOSS_OF_SYNC;
          cc_n    = '0;
          gc_n    = '0;
          bl_n    = '0;
        end
      endcase
    end
    status_n = (state_n == SYNC_ACQUIRED) ||
               (state_n == SYNC_RECOVER);
  end

  always_ff @(posedge Clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state            <= LOSS_OF_SYNC;
      rx_even          <= 1'b0;
      comma_cnt        <= '0;
      good_cnt         <= '0;
      bad_lvl          <= '0;
      code_sync_status <= 1'b0;
      SUDI             <= '0;
      sync_loss_count  <= '0;
    end else if (power_on) begin
      state            <= LOSS_OF_SYNC;
      rx_even          <= 1'b0;
      comma_cnt        <= '0;
      good_cnt         <= '0;
      bad_lvl          <= '0;
      code_sync_status <= 1'b0;
      SUDI             <= '0;
    end else begin
      state            <= state_n;
      rx_even          <= rxe_n;
      comma_cnt        <= cc_n;
      good_cnt         <= gc_n;
      bad_lvl          <= bl_n;
      code_sync_status <= status_n;
      SUDI             <= {PUDI, rx_even};
      if (code_sync_status && !status_n &&
          (sync_loss_count != '1))
        sync_loss_count <= sync_loss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pcs_sync_param.sv
// Directed bench for pcs_sync_param.
// Walks acquire, loss, recovery, odd commas, signal_detect, power_on, saturation, async reset.
module tb_pcs_sync_param;

  logic        Clk = 1'b0;
  logic        mr_main_reset_n;
  logic        power_on;
  logic        signal_detect;
  logic [9:0]  PUDI;
  logic        code_sync_status;
  logic        rx_even;
  logic [10:0] SUDI;
  logic [7:0]  sync_loss_count;

  localparam logic [9:0] K   = 10'b0011111010;
  localparam logic [9:0] D   = 10'b1001000101;
  localparam logic [9:0] D21 = 10'b1010101010;
  localparam logic [9:0] Z   = 10'b0000000000;

  int n_chk  = 0;
  int n_fail = 0;

  pcs_sync_param dut (
    .Clk              (Clk),
    .mr_main_reset_n  (mr_main_reset_n),
    .power_on         (power_on),
    .signal_detect    (signal_detect),
    .PUDI             (PUDI),
    .code_sync_status (code_sync_status),
    .rx_even          (rx_even),
    .SUDI             (SUDI),
    .sync_loss_count  (sync_loss_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // erxe/estat < 0 skip that check
  task automatic cyc(input logic [9:0] p,
                     input int erxe,
                     input int estat);
    if (erxe >= 0)
      check("rx_even", {31'b0, rx_even}, erxe);
    PUDI = p;
    @(posedge Clk);
    #1;
    if (erxe >= 0)
      check("sudi", {21'b0, SUDI}, {21'b0, p, erxe[0]});
    if (estat >= 0)
      check("status", {31'b0, code_sync_status}, estat);
  endtask

  task automatic drv(input logic [9:0] p, input logic sd);
    PUDI = p;
    signal_detect = sd;
    @(posedge Clk);
    #1;
    signal_detect = 1'b1;
  endtask

  task automatic acq(input int rxe0);
    cyc(K, rxe0, 0);
    cyc(D, 0, 0);
    cyc(K, 1, 0);
    cyc(D, 0, 0);
    cyc(K, 1, 0);
    cyc(D, 0, 1);
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    check(tag, {24'b0, sync_loss_count}, exp);
  endtask

  initial begin
    mr_main_reset_n = 1'b0;
    power_on        = 1'b0;
    signal_detect   = 1'b1;
    PUDI            = Z;
    #12;
    check("rst_status", {31'b0, code_sync_status}, 0);
    check("rst_rxe", {31'b0, rx_even}, 0);
    check("rst_sudi", {21'b0, SUDI}, 0);
    chk_cnt("rst_cnt", 0);
    mr_main_reset_n = 1'b1;

    // acquisition from reset, status from cycle 6
    acq(0);
    cyc(K, 1, 1);
    cyc(D, 0, 1);

    // four invalids lose sync
    cyc(Z, 1, 1);
    cyc(Z, 0, 1);
    cyc(Z, 1, 1);
    cyc(Z, 0, 0);
    chk_cnt("loss_cnt1", 1);
    acq(1);

    // 3 bad, 8 good (-2 levels), 1 bad -> level 2
    cyc(Z, 1, 1);
    cyc(Z, 0, 1);
    cyc(Z, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(D21, 0, 1);
      cyc(K, 1, 1);
    end
    cyc(Z, 0, 1);
    cyc(Z, 1, 1);
    cyc(Z, 0, 0);
    chk_cnt("loss_cnt2", 2);

    // odd comma during acquisition
    cyc(K, 1, 0);
    cyc(D, 0, 0);
    cyc(D, 1, 0);
    cyc(K, 0, 0);
    acq(1);

    // odd comma in sync is one bad code-group
    cyc(D, 1, 1);
    cyc(K, 0, 1);
    cyc(Z, 1, 1);
    cyc(Z, 0, 1);
    cyc(Z, 1, 0);
    chk_cnt("loss_cnt3", 3);

    // signal_detect drop
    acq(0);
    signal_detect = 1'b0;
    cyc(D, 1, 0);
    signal_detect = 1'b1;
    chk_cnt("sd_cnt", 4);

    // power_on in sync: no count
    acq(0);
    power_on = 1'b1;
    cyc(D, -1, 0);
    power_on = 1'b0;
    check("po_rxe", {31'b0, rx_even}, 0);
    check("po_sudi", {21'b0, SUDI}, 0);
    chk_cnt("po_cnt", 4);
    acq(0);

    // saturate the loss counter
    for (int i = 0; i < 251; i++) begin
      for (int j = 0; j < 3; j++) begin
        drv(K, 1'b1);
        drv(D, 1'b1);
      end
      drv(D, 1'b0);
    end
    chk_cnt("cnt_255", 255);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) begin
        drv(K, 1'b1);
        drv(D, 1'b1);
      end
      drv(D, 1'b0);
    end
    chk_cnt("cnt_sat", 255);

    // async reset mid-acquisition
    drv(K, 1'b1);
    drv(D, 1'b1);
    drv(K, 1'b1);
    #2;
    mr_main_reset_n = 1'b0;
    #1;
    check("arst_status", {31'b0, code_sync_status}, 0);
    check("arst_rxe", {31'b0, rx_even}, 0);
    check("arst_sudi", {21'b0, SUDI}, 0);
    chk_cnt("arst_cnt", 0);
    #1;
    mr_main_reset_n = 1'b1;
    acq(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_sync_param.md
Name: pcs_sync_param

Overview:
- Parametrised 1000BASE-X PCS receive synchronization FSM, successor to the fixed-threshold synchronizer.
- Sits between the PMA deserializer output (PUDI) and the receive state machine (SUDI).
- Adds built-in comma, /D/ and coarse code-group validity detection, configurable acquire/loss/recovery thresholds, a signal_detect override and a saturating loss-event counter.

Parameters:
ACQ_COMMAS, 3, even-aligned comma+/D/ pairs required to declare sync (>=1)
GOOD_CGS_MAX, 4, consecutive good code-groups that remove one bad level (>=1)
LOSS_STEPS, 4, unrecovered bad code-groups in sync that cause loss of sync (>=1)
CNT_W, 8, width of sync_loss_count

Ports:
Clk  input  1  clock, all state on rising edge
mr_main_reset_n  input  1  asynchronous active-low reset
power_on  input  1  synchronous active-high FSM re-init; does not clear sync_loss_count
signal_detect  input  1  PMA signal present; low forces LOSS_OF_SYNC
PUDI  input  10  received code-group; [9:4]=abcdei, [3:0]=fghj
code_sync_status  output  1  registered sync status
rx_even  output  1  parity of the code-group currently on PUDI (1=even)
SUDI  output  11  registered {PUDI, rx_even}
sync_loss_count  output  CNT_W  saturating count of sync-to-loss transitions

Behaviour:
- Reset (mr_main_reset_n=0, async): state=LOSS_OF_SYNC, rx_even=0, code_sync_status=0, SUDI=0, sync_loss_count=0, all internal counters=0.
- power_on=1 at an edge: same as reset except sync_loss_count is held.
- Decode (combinational on PUDI):
  - comma = PUDI[9:3] is 0011111 or 1100000.
  - invalid = total ones not in 4..6, OR PUDI[9:4] ones not in 2..4, OR PUDI[3:0] ones not in 1..3.
  - Kcode = PUDI[9:4] is 001111/110000, OR PUDI is one of K23.7/K27.7/K29.7/K30.7 in either RD.
  - isD = ~invalid & ~Kcode.
  - cggood = ~(invalid | (comma & ~rx_even)); a comma on an odd position is bad.
- FSM, internal comma_cnt, bad_lvl (0..LOSS_STEPS-1) and good_cnt:
  - LOSS_OF_SYNC: status 0.
    - Comma: next_rx_even=0, comma_cnt=1, go to COMMA_DETECT.
    - Otherwise: rx_even toggles.
  - COMMA_DETECT: next_rx_even=1.
    - isD and comma_cnt==ACQ_COMMAS: go to SYNC_ACQUIRED, bad_lvl=0.
    - isD otherwise: go to ACQUIRE_SYNC.
    - Not isD: go to LOSS_OF_SYNC.
  - ACQUIRE_SYNC: rx_even toggles.
    - comma & rx_even: comma_cnt+1, go to COMMA_DETECT.
    - Else ~cggood: go to LOSS_OF_SYNC.
    - Else: stay.
  - SYNC_ACQUIRED (bad_lvl=0): rx_even toggles.
    - ~cggood: bad_lvl=1, good_cnt=0, go to SYNC_RECOVER. If LOSS_STEPS==1, go to LOSS_OF_SYNC instead.
  - SYNC_RECOVER: rx_even toggles.
    - cggood: good_cnt+1. When good_cnt reaches GOOD_CGS_MAX: bad_lvl-1, good_cnt=0; at bad_lvl 0 go to SYNC_ACQUIRED.
    - ~cggood: good_cnt=0, bad_lvl+1; reaching LOSS_STEPS goes to LOSS_OF_SYNC.
- code_sync_status is registered: 1 iff next state is SYNC_ACQUIRED or SYNC_RECOVER. It rises/falls one cycle after the deciding code-group.
- signal_detect=0 overrides every transition: next state LOSS_OF_SYNC, counters cleared, rx_even toggles.
- sync_loss_count: +1 on every edge where code_sync_status goes 1->0 (any cause, including signal_detect). Saturates at all-ones. Not incremented by power_on.
- SUDI <= {PUDI, rx_even} every edge, 1-cycle latency, independent of state.
- Illegal/unreachable state encoding: go to LOSS_OF_SYNC next edge.
- Counter widths sized by $clog2 of their maxima; no wrap-around is possible.

Test Plan:
1. Reset, then alternate K28.5- 10'b0011111010 / D16.2 10'b1001000101 starting at cycle 0 -> code_sync_status=1 from cycle 6; rx_even=1 on every K28.5 cycle; SUDI equals the previous cycle's {PUDI, rx_even}.
2. In sync, 4 consecutive 10'b0000000000 -> status 0 one cycle after the 4th; sync_loss_count=1; FSM reacquires with test 1 stream.
3. In sync, 3 invalids then 8 good code-groups (D21.5 10'b1010101010 / K28.5 alternating, comma even) then 1 invalid -> status stays 1 throughout (bad_lvl 3->1->2).
4. K28.5 presented on an odd position during ACQUIRE_SYNC -> LOSS_OF_SYNC next edge, status stays 0; same while in sync counts as one bad code-group.
5. In sync, signal_detect=0 for 1 cycle -> status 0 next cycle, sync_loss_count +1. Then power_on pulse -> state LOSS, sync_loss_count unchanged.
6. Force sync_loss_count to 255 via repeated losses (CNT_W=8) -> stays 255. Async reset mid-acquisition (comma_cnt=2) -> all outputs 0 immediately, no clock edge needed.
